// File: rtl/rsa_csr_pkg.sv
// rsa_csr_pkg: CSR byte offsets, AXI response codes, FSM encodings
// and the byte-strobe merge helper for the RSA CSR responder.
package rsa_csr_pkg;

  // Write map (byte offsets)
  localparam logic [11:0] OFF_COMMAND  = 12'h000;
  localparam logic [11:0] OFF_RXADDR   = 12'h004;
  localparam logic [11:0] OFF_TXADDR   = 12'h008;
  localparam logic [11:0] OFF_T        = 12'h00C;
  localparam logic [11:0] OFF_T_LEN    = 12'h010;
  localparam logic [11:0] OFF_LOADING  = 12'h014;

  // Read map (byte offsets), independent of the write map
  localparam logic [11:0] OFF_STATUS   = 12'h000;
  localparam logic [11:0] OFF_LSB_N    = 12'h004;
  localparam logic [11:0] OFF_LSB_R_N  = 12'h008;
  localparam logic [11:0] OFF_LSB_R2_N = 12'h00C;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_COMMIT,
    WR_RESP
  } wr_state_e;

  typedef enum logic {
    RD_IDLE,
    RD_RESP
  } rd_state_e;

  function automatic logic [31:0] strb_merge(
    input logic [31:0] old_v,
    input logic [31:0] new_v,
    input logic [3:0]  strb
  );
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/rsa_csr_axil_slave.sv
// rsa_csr_axil_slave: AXI4-Lite CSR responder for the RSA core.
// Ports: s_axi_csrs_* AXI-Lite slave; six write registers out
// (command..loading) plus command_wr pulse; four read-only
// status/modulus sources in. Independent write and read FSMs.
module rsa_csr_axil_slave
  import rsa_csr_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] s_axi_csrs_awaddr,
  input  logic              s_axi_csrs_awvalid,
  output logic              s_axi_csrs_awready,
  input  logic [DATA_W-1:0] s_axi_csrs_wdata,
  input  logic [3:0]        s_axi_csrs_wstrb,
  input  logic              s_axi_csrs_wvalid,
  output logic              s_axi_csrs_wready,
  output logic [1:0]        s_axi_csrs_bresp,
  output logic              s_axi_csrs_bvalid,
  input  logic              s_axi_csrs_bready,
  input  logic [ADDR_W-1:0] s_axi_csrs_araddr,
  input  logic              s_axi_csrs_arvalid,
  output logic              s_axi_csrs_arready,
  output logic [DATA_W-1:0] s_axi_csrs_rdata,
  output logic [1:0]        s_axi_csrs_rresp,
  output logic              s_axi_csrs_rvalid,
  input  logic              s_axi_csrs_rready,
  output logic [DATA_W-1:0] command,
  output logic [DATA_W-1:0] rxaddr,
  output logic [DATA_W-1:0] txaddr,
  output logic [DATA_W-1:0] t_exp,
  output logic [DATA_W-1:0] t_len,
  output logic [DATA_W-1:0] loading,
  output logic              command_wr,
  input  logic [DATA_W-1:0] core_status,
  input  logic [DATA_W-1:0] lsb_n,
  input  logic [DATA_W-1:0] lsb_r_n,
  input  logic [DATA_W-1:0] lsb_r2_n
);

  wr_state_e         wr_st_q, wr_st_d;
  logic              aw_pend_q, aw_pend_d;
  logic              w_pend_q, w_pend_d;
  logic [ADDR_W-1:2] awaddr_q, awaddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              cmd_wr_q, cmd_wr_d;
  logic [DATA_W-1:0] regs_q [6];
  logic [DATA_W-1:0] regs_d [6];

  rd_state_e         rd_st_q, rd_st_d;
  logic              rvalid_q, rvalid_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              aw_hs, w_hs, ar_hs;
  logic [ADDR_W-1:0] wa, ra;
  logic              unused_addr_lsbs;

  // Byte lanes within a word are not decoded
  assign unused_addr_lsbs = ^{s_axi_csrs_awaddr[1:0],
                              s_axi_csrs_araddr[1:0]};

  assign s_axi_csrs_awready = !aw_pend_q && (wr_st_q == WR_IDLE);
  assign s_axi_csrs_wready  = !w_pend_q && (wr_st_q == WR_IDLE);
  assign s_axi_csrs_arready = (rd_st_q == RD_IDLE);

  assign aw_hs = s_axi_csrs_awvalid && s_axi_csrs_awready;
  assign w_hs  = s_axi_csrs_wvalid && s_axi_csrs_wready;
  assign ar_hs = s_axi_csrs_arvalid && s_axi_csrs_arready;

  assign wa = {awaddr_q, 2'b00};
  assign ra = {s_axi_csrs_araddr[ADDR_W-1:2], 2'b00};

  always_comb begin
    wr_st_d   = wr_st_q;
    aw_pend_d = aw_pend_q;
    w_pend_d  = w_pend_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    cmd_wr_d  = 1'b0;
    regs_d    = regs_q;
    unique case (wr_st_q)
      WR_IDLE: begin
        if (aw_hs) begin
          aw_pend_d = 1'b1;
          awaddr_d  = s_axi_csrs_awaddr[ADDR_W-1:2];
        end
        if (w_hs) begin
          w_pend_d = 1'b1;
          wdata_d  = s_axi_csrs_wdata;
          wstrb_d  = s_axi_csrs_wstrb;
        end
        if (aw_pend_d && w_pend_d) wr_st_d = WR_COMMIT;
      end
      WR_COMMIT: begin
        aw_pend_d = 1'b0;
        w_pend_d  = 1'b0;
        bvalid_d  = 1'b1;
        bresp_d   = RESP_OKAY;
        wr_st_d   = WR_RESP;
        unique case (wa)
          OFF_COMMAND: begin
            regs_d[0] = strb_merge(regs_q[0], wdata_q, wstrb_q);
            cmd_wr_d  = 1'b1;
          end
          OFF_RXADDR:  regs_d[1] = strb_merge(regs_q[1], wdata_q, wstrb_q);
          OFF_TXADDR:  regs_d[2] = strb_merge(regs_q[2], wdata_q, wstrb_q);
          OFF_T:       regs_d[3] = strb_merge(regs_q[3], wdata_q, wstrb_q);
          OFF_T_LEN:   regs_d[4] = strb_merge(regs_q[4], wdata_q, wstrb_q);
          OFF_LOADING: regs_d[5] = strb_merge(regs_q[5], wdata_q, wstrb_q);
          default:     bresp_d   = RESP_SLVERR;
        endcase
      end
      WR_RESP: begin
        if (s_axi_csrs_bready) begin
          bvalid_d = 1'b0;
          wr_st_d  = WR_IDLE;
        end
      end
      default: wr_st_d = WR_IDLE;
    endcase
  end

  // Read-only sources are captured at the AR handshake edge
  always_comb begin
    rd_st_d  = rd_st_q;
    rvalid_d = rvalid_q;
    rresp_d  = rresp_q;
    rdata_d  = rdata_q;
    unique case (rd_st_q)
      RD_IDLE: begin
        if (ar_hs) begin
          rvalid_d = 1'b1;
          rresp_d  = RESP_OKAY;
          rd_st_d  = RD_RESP;
          unique case (ra)
            OFF_STATUS:   rdata_d = core_status;
            OFF_LSB_N:    rdata_d = lsb_n;
            OFF_LSB_R_N:  rdata_d = lsb_r_n;
            OFF_LSB_R2_N: rdata_d = lsb_r2_n;
            default: begin
              rdata_d = '0;
              rresp_d = RESP_SLVERR;
            end
          endcase
        end
      end
      RD_RESP: begin
        if (s_axi_csrs_rready) begin
          rvalid_d = 1'b0;
          rd_st_d  = RD_IDLE;
        end
      end
      default: rd_st_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_st_q   <= WR_IDLE;
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      cmd_wr_q  <= 1'b0;
      for (int i = 0; i < 6; i++) regs_q[i] <= '0;
      rd_st_q   <= RD_IDLE;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      wr_st_q   <= wr_st_d;
      aw_pend_q <= aw_pend_d;
      w_pend_q  <= w_pend_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      cmd_wr_q  <= cmd_wr_d;
      for (int i = 0; i < 6; i++) regs_q[i] <= regs_d[i];
      rd_st_q   <= rd_st_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

  assign s_axi_csrs_bvalid = bvalid_q;
  assign s_axi_csrs_bresp  = bresp_q;
  assign s_axi_csrs_rvalid = rvalid_q;
  assign s_axi_csrs_rresp  = rresp_q;
  assign s_axi_csrs_rdata  = rdata_q;
  assign command_wr        = cmd_wr_q;
  assign command           = regs_q[0];
  assign rxaddr            = regs_q[1];
  assign txaddr            = regs_q[2];
  assign t_exp             = regs_q[3];
  assign t_len             = regs_q[4];
  assign loading           = regs_q[5];

endmodule

// File: tb/tb_rsa_csr_axil_slave.sv
// tb_rsa_csr_axil_slave: directed scoreboard bench for the
// RSA CSR AXI4-Lite responder.
module tb_rsa_csr_axil_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [11:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] command, rxaddr, txaddr, t_exp, t_len, loading;
  logic        command_wr;
  logic [31:0] core_status, lsb_n, lsb_r_n, lsb_r2_n;

  int checks = 0;
  int failures = 0;

  logic [1:0]  bq [$];
  logic [33:0] rq [$];

  always #5 clk = ~clk;

  rsa_csr_axil_slave dut (
    .clk                (clk),
    .rst                (rst),
    .s_axi_csrs_awaddr  (awaddr),
    .s_axi_csrs_awvalid (awvalid),
    .s_axi_csrs_awready (awready),
    .s_axi_csrs_wdata   (wdata),
    .s_axi_csrs_wstrb   (wstrb),
    .s_axi_csrs_wvalid  (wvalid),
    .s_axi_csrs_wready  (wready),
    .s_axi_csrs_bresp   (bresp),
    .s_axi_csrs_bvalid  (bvalid),
    .s_axi_csrs_bready  (bready),
    .s_axi_csrs_araddr  (araddr),
    .s_axi_csrs_arvalid (arvalid),
    .s_axi_csrs_arready (arready),
    .s_axi_csrs_rdata   (rdata),
    .s_axi_csrs_rresp   (rresp),
    .s_axi_csrs_rvalid  (rvalid),
    .s_axi_csrs_rready  (rready),
    .command            (command),
    .rxaddr             (rxaddr),
    .txaddr             (txaddr),
    .t_exp              (t_exp),
    .t_len              (t_len),
    .loading            (loading),
    .command_wr         (command_wr),
    .core_status        (core_status),
    .lsb_n              (lsb_n),
    .lsb_r_n            (lsb_r_n),
    .lsb_r2_n           (lsb_r2_n)
  );

  task automatic chk(input string nm, input logic [33:0] act,
                     input logic [33:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Monitor: pops the expected response whenever a handshake occurs
  initial begin
    forever begin
      @(negedge clk);
      if (bvalid && bready) begin
        if (bq.size() == 0) chk("b_unexpected", 34'd1, 34'd0);
        else chk("bresp", {32'd0, bresp}, {32'd0, bq.pop_front()});
      end
      if (rvalid && rready) begin
        if (rq.size() == 0) chk("r_unexpected", 34'd1, 34'd0);
        else chk("rdata_rresp", {rdata, rresp}, rq.pop_front());
      end
    end
  end

  task automatic axw(input logic [11:0] a, input logic [31:0] d,
                     input logic [3:0] s, input logic [1:0] er);
    bit ok;
    bq.push_back(er);
    @(posedge clk); #1;
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (awready && wready) begin ok = 1'b1; break; end
    end
    chk("wr_accept", {33'd0, ok}, 34'd1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    chk("bvalid_e0", {33'd0, bvalid}, 34'd0);
    @(negedge clk);
    chk("bvalid_e1", {33'd0, bvalid}, 34'd1);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!bvalid && awready && wready) begin ok = 1'b1; break; end
    end
    chk("wr_done", {33'd0, ok}, 34'd1);
  endtask

  task automatic axr(input logic [11:0] a, input logic [31:0] ed,
                     input logic [1:0] er);
    bit ok;
    rq.push_back({ed, er});
    @(posedge clk); #1;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (arready) begin ok = 1'b1; break; end
    end
    chk("ar_accept", {33'd0, ok}, 34'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    @(negedge clk);
    chk("rvalid_e0", {33'd0, rvalid}, 34'd1);
    @(negedge clk);
    chk("rvalid_e1", {32'd0, rvalid, arready}, 34'd1);
  endtask

  initial begin
    int  pulses;
    bit  ok;
    rst = 1'b1;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0;
    wvalid = 1'b0; bready = 1'b1; araddr = '0; arvalid = 1'b0;
    rready = 1'b1;
    core_status = 32'h0; lsb_n = 32'h1234_5678;
    lsb_r_n = 32'hA5A5_0001; lsb_r2_n = 32'h0BAD_F00D;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_readies", {31'd0, awready, wready, arready}, 34'd7);
    chk("rst_valids", {31'd0, bvalid, rvalid, command_wr}, 34'd0);
    chk("rst_resp", {30'd0, bresp, rresp}, 34'd0);
    chk("rst_rdata", {2'd0, rdata}, 34'd0);
    chk("rst_regs_a", {2'd0, command | rxaddr | txaddr}, 34'd0);
    chk("rst_regs_b", {2'd0, t_exp | t_len | loading}, 34'd0);

    // AW and W together
    axw(12'd16, 32'd16, 4'hF, 2'b00);
    chk("t_len", {2'd0, t_len}, 34'd16);

    // W two cycles ahead of AW, COMMAND write
    bq.push_back(2'b00);
    @(posedge clk); #1;
    wdata = 32'h9; wstrb = 4'hF; wvalid = 1'b1; awaddr = 12'd0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (wready) begin ok = 1'b1; break; end
    end
    chk("w_accept", {33'd0, ok}, 34'd1);
    @(posedge clk); #1 wvalid = 1'b0;
    @(negedge clk);
    chk("w_wait1", {32'd0, wready, awready}, 34'd1);
    @(posedge clk); #1 awvalid = 1'b1;
    @(negedge clk);
    chk("w_wait2", {32'd0, wready, awready}, 34'd1);
    @(posedge clk); #1 awvalid = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (command_wr) pulses++;
    end
    chk("cmd_wr_pulses", 34'(pulses), 34'd1);
    chk("command", {2'd0, command}, 34'h9);

    // Read STATUS with rready held low, source changes after AR
    core_status = 32'h1;
    rq.push_back({32'h1, 2'b00});
    @(posedge clk); #1;
    araddr = 12'd0; arvalid = 1'b1; rready = 1'b0;
    @(negedge clk);
    chk("ar_ready_idle", {33'd0, arready}, 34'd1);
    @(posedge clk); #1;
    arvalid = 1'b0; core_status = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("r_hold", {rdata, rvalid, arready}, {32'h1, 2'b10});
    end
    @(posedge clk); #1 rready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!rvalid && arready) begin ok = 1'b1; break; end
    end
    chk("r_done", {33'd0, ok}, 34'd1);

    // Read latency with rready high, plus ignored low address bits
    axr(12'd4, 32'h1234_5678, 2'b00);
    axr(12'd13, 32'h0BAD_F00D, 2'b00);
    axr(12'd8, 32'hA5A5_0001, 2'b00);

    // Strobe merge onto LOADING, then zero strobe
    axw(12'd20, 32'h0000_1200, 4'hF, 2'b00);
    axw(12'd20, 32'hFFFF_FF0B, 4'b0001, 2'b00);
    chk("loading_merge", {2'd0, loading}, 34'h0000_120B);
    axw(12'd20, 32'hFFFF_FFFF, 4'b0000, 2'b00);
    chk("loading_strb0", {2'd0, loading}, 34'h0000_120B);
    axw(12'd6, 32'h0000_00A5, 4'hF, 2'b00);
    chk("rxaddr", {2'd0, rxaddr}, 34'hA5);
    axw(12'd12, 32'hCAFE_0000, 4'b1100, 2'b00);
    chk("t_exp", {2'd0, t_exp}, 34'hCAFE_0000);

    // Unmapped write and read
    axw(12'd24, 32'hFFFF_FFFF, 4'hF, 2'b10);
    chk("unm_cmd", {2'd0, command}, 34'h9);
    chk("unm_rx", {2'd0, rxaddr}, 34'hA5);
    chk("unm_tx", {2'd0, txaddr}, 34'h0);
    chk("unm_t", {2'd0, t_exp}, 34'hCAFE_0000);
    chk("unm_tlen", {2'd0, t_len}, 34'd16);
    chk("unm_load", {2'd0, loading}, 34'h0000_120B);
    axr(12'd40, 32'h0, 2'b10);

    repeat (3) @(negedge clk);
    chk("bq_left", 34'(bq.size()), 34'd0);
    chk("rq_left", 34'(rq.size()), 34'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
